// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequential shift-and-add multiplier with IDLE/RUN/DONE control
// Computes p = a*b + cin over WIDTH run cycles; result register holds until the next completion.
module mul_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p,
    output logic [WIDTH-1:0]     s,
    output logic                 cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_p;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_sum;
    logic               w_last;

    always_comb begin
        w_next_state = r_state;
        w_addend     = r_b[r_count] ? ({{WIDTH{1'b0}}, r_a} << r_count) : '0;
        w_sum        = r_acc + w_addend;
        w_last       = (r_count == CW'(WIDTH - 1));
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // cin seeds the accumulator LSB so the final sum is a*b + cin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_count <= '0;
            r_acc   <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= {{(2*WIDTH-1){1'b0}}, cin};
                        r_count <= '0;
                    end
                end
                RUN: begin
                    r_acc   <= w_sum;
                    r_count <= r_count + CW'(1);
                    if (w_last) r_p <= w_sum;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign p    = r_p;
    assign s    = r_p[WIDTH-1:0];
    assign cout = |r_p[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed self-checking bench for mul_seq_ctrl (WIDTH=16)
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] p;
    logic [15:0] s;
    logic        cout;

    int errors = 0;
    int checks = 0;

    mul_seq_ctrl #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .p    (p),
        .s    (s),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One start pulse; sample k is taken at the falling edge after rising edge k (k=0 is the start edge).
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                          output int done_at, output int busy_n, output int done_n,
                          output logic [31:0] p_mid);
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        done_at = -1; busy_n = 0; done_n = 0; p_mid = 'x;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k == 8) p_mid = p;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (p !== 32'h0) begin errors++; $display("FAIL reset_p got=%h want=00000000", p); end
        checks++; if (s !== 16'h0) begin errors++; $display("FAIL reset_s got=%h want=0000", s); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b want=0", cout); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int da, bn, dn;
        logic [31:0] pm;
        run_op(16'd3, 16'd5, 1'b0, da, bn, dn, pm);
        checks++; if (bn !== 17) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=17", bn); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_cycles got=%0d want=1", dn); end
        checks++; if (da !== 16) begin errors++; $display("FAIL basic_done_edge got=%0d want=16", da); end
        checks++; if (p !== 32'h0000000F) begin errors++; $display("FAIL basic_p got=%h want=0000000f", p); end
        checks++; if (s !== 16'h000F) begin errors++; $display("FAIL basic_s got=%h want=000f", s); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b want=0", cout); end
    endtask

    task automatic test_max();
        int da, bn, dn;
        logic [31:0] pm;
        run_op(16'hFFFF, 16'hFFFF, 1'b1, da, bn, dn, pm);
        checks++; if (p !== 32'hFFFE0002) begin errors++; $display("FAIL max_p got=%h want=fffe0002", p); end
        checks++; if (s !== 16'h0002) begin errors++; $display("FAIL max_s got=%h want=0002", s); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL max_cout got=%b want=1", cout); end
        checks++; if (pm !== 32'h0000000F) begin errors++; $display("FAIL max_hold_p got=%h want=0000000f", pm); end
    endtask

    task automatic test_boundary();
        int da, bn, dn;
        logic [31:0] pm;
        run_op(16'h8000, 16'd2, 1'b0, da, bn, dn, pm);
        checks++; if (p !== 32'h00010000) begin errors++; $display("FAIL shift_p got=%h want=00010000", p); end
        checks++; if (s !== 16'h0000) begin errors++; $display("FAIL shift_s got=%h want=0000", s); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL shift_cout got=%b want=1", cout); end
        run_op(16'h1234, 16'h0000, 1'b0, da, bn, dn, pm);
        checks++; if (pm !== 32'h00010000) begin errors++; $display("FAIL zero_hold_p got=%h want=00010000", pm); end
        checks++; if (da !== 16) begin errors++; $display("FAIL zero_done_edge got=%0d want=16", da); end
        checks++; if (p !== 32'h0) begin errors++; $display("FAIL zero_p got=%h want=00000000", p); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL zero_cout got=%b want=0", cout); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        a = 16'd4; b = 16'd11; cin = 1'b0; start = 1'b1;
        repeat (5) @(negedge clk);
        a = 16'd7; b = 16'd9;
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b want=1", done); end
        checks++; if (p !== 32'd44) begin errors++; $display("FAIL b2b_first_p got=%0d want=44", p); end
        n = 0;
        while (done && n < 40) begin @(negedge clk); n++; end
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b want=1", done); end
        checks++; if (p !== 32'd63) begin errors++; $display("FAIL b2b_second_p got=%0d want=63", p); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_async_reset();
        int da, bn, dn;
        logic [31:0] pm;
        run_op(16'h8000, 16'd4, 1'b0, da, bn, dn, pm);
        checks++; if (p !== 32'h00020000) begin errors++; $display("FAIL pre_rst_p got=%h want=00020000", p); end
        @(negedge clk);
        a = 16'h00FF; b = 16'h00FF; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (p !== 32'h0) begin errors++; $display("FAIL arst_p got=%h want=00000000", p); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got=%b want=0", done); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL arst_cout got=%b want=0", cout); end
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL arst_no_done got=%0d want=0", dn); end
        run_op(16'd2, 16'd3, 1'b0, da, bn, dn, pm);
        checks++; if (da !== 16) begin errors++; $display("FAIL post_rst_done_edge got=%0d want=16", da); end
        checks++; if (p !== 32'd6) begin errors++; $display("FAIL post_rst_p got=%0d want=6", p); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_boundary();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
